spi_xfer_arbiter: RTL and testbench
===================================

Name: spi_xfer_arbiter

Overview:
- Round-robin scheduler that shares one 8-bit SPI clock/shift engine between N_REQ requesters.
- Each requester supplies its own mode (cpol/cpha) and data byte. The arbiter grants one requester, latches its configuration, pulses the engine start, and tracks the engine chip-select to detect completion. It then returns a done pulse to the winner.
- Sits between the protocol-select/host logic and the SPI engine.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 8, data byte width presented to the engine.
- GAP_CYC, 4, idle clk cycles enforced between the end of one transfer and the next launch (min 1).
- TO_CYC, 255, max clk cycles allowed in each wait state before a timeout is declared.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester transfer request, level; held high until that requester's done.
- req_cpol  in  N_REQ  per-requester clock polarity.
- req_cpha  in  N_REQ  per-requester clock phase.
- req_dat  in  N_REQ*DW  per-requester byte; requester i occupies bits [i*DW +: DW].
- gnt  out  N_REQ  one-hot grant, high from ARB exit until done.
- done  out  N_REQ  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse coincident with done when the transfer timed out.
- busy  out  1  high in every state except IDLE.
- active_id  out  $clog2(N_REQ)  index of the current/last granted requester.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_cpol  out  1  latched cpol to the engine.
- eng_cpha  out  1  latched cpha to the engine.
- eng_dat  out  DW  latched data to the engine.
- eng_cs  in  1  engine chip-select, active low; low means transfer in progress.

Behaviour:
- Reset (async assert, sync release) values:
  - state=IDLE.
  - gnt=0, done=0, err=0, busy=0, eng_start=0, eng_cpol=0, eng_cpha=0, eng_dat=0, active_id=0.
  - rr_ptr=0, timer=0.
- Reset asserted mid-transfer aborts immediately. No done is issued. The engine is left to finish on its own.
- FSM states:
  - IDLE: if any req bit is set, go to ARB.
  - ARB (1 cycle):
    - Winner = first set req bit searching upward from rr_ptr, wrapping at N_REQ.
    - Latch that requester's cpol, cpha and dat into eng_*. Set active_id and gnt (one-hot). Go to LAUNCH.
    - If req is zero by this cycle, return to IDLE with no grant.
  - LAUNCH (1 cycle): eng_start=1; timer cleared; go to WAIT_LO.
  - WAIT_LO: on eng_cs==0 go to WAIT_HI with timer cleared. If timer reaches TO_CYC, go to FIN with to_flag set.
  - WAIT_HI: on eng_cs==1 go to FIN. If timer reaches TO_CYC, go to FIN with to_flag set.
  - FIN (1 cycle):
    - done[active_id]=1 and err=to_flag.
    - gnt cleared at end of cycle.
    - rr_ptr = active_id+1, wrapping to 0 at N_REQ.
    - Go to GAP.
  - GAP: count GAP_CYC cycles with busy=1, then go to IDLE.
- Latency: req rising in IDLE gives gnt 1 cycle later and eng_start 2 cycles later.
- eng_cpol, eng_cpha and eng_dat are stable from LAUNCH through FIN. They change only in ARB. Requester input changes after the grant are ignored.
- A requester dropping req while granted does not abort; the transfer completes and done is still pulsed.
- A req bit newly set while busy is considered at the next ARB only.
- The same requester may win back-to-back only if no other req bit is set.
- Timer is 8 bits or $clog2(TO_CYC+1) bits and saturates; no wrap.
- eng_cs already low in LAUNCH (stale engine) is accepted as a transfer start.
- Outputs done, err and eng_start are registered; never combinational from inputs.

Decomposition:
- Shared package spi_ctrl_pkg holds:
  - state encoding enum (IDLE, ARB, LAUNCH, WAIT_LO, WAIT_HI, FIN, GAP);
  - localparam IDW = $clog2(N_REQ);
  - mode encoding constants {cpol,cpha}: MODE0..MODE3.
- One natural sub-module, rr_pick: combinational round-robin priority picker. Inputs req and rr_ptr; outputs a one-hot winner, its index, and a valid flag.

Test Plan:
- Single request: req=0001, cpol=0, cpha=0, dat=8'hA5; engine model drives cs low 3 cycles after start and high after 34 → gnt=0001 at +1, eng_start at +2, eng_dat=A5, done[0] one cycle after cs rises, err=0.
- Fairness: req=1111 held continuously → grant order 0,1,2,3,0. Each done is followed by GAP_CYC=4 busy cycles before the next gnt.
- Config latching: requester 2 wins with dat=3C and mode 3 (cpol=1, cpha=1), then changes dat to FF after the grant → eng_dat stays 3C and eng_cpol/eng_cpha stay 1/1 until FIN.
- Timeout: engine never lowers cs → done[active_id] and err pulse together at TO_CYC+1 cycles after LAUNCH; next arbitration proceeds normally.
- Reset mid-transfer: rst_n low during WAIT_HI → all outputs 0 asynchronously, no done pulse; after release, req=0100 is granted with rr_ptr=0.
- Request withdrawal: req[1] drops during WAIT_LO → transfer still completes and done[1] pulses.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI transfer arbiter: FSM encoding, id width
// and the {cpol,cpha} mode encodings.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LAUNCH,
    WAIT_LO,
    WAIT_HI,
    FIN,
    GAP
  } state_t;

  localparam int N_REQ_DFLT = 4;
  localparam int IDW        = $clog2(N_REQ_DFLT);

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic logic [1:0] mode_of(input logic cpol, input logic cpha);
    return {cpol, cpha};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr,
// wrapping at N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [IW-1:0]    win_idx,
  output logic             win_vld
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [2*N_REQ-1:0] req_rot;
  logic [IW-1:0]      off;
  logic [IW:0]        idx_sum;

  // Doubling the vector lets a plain shift act as a rotate so rr_ptr lands on bit 0.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl >> rr_ptr;
  assign win_vld = |req;

  always_comb begin
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        off = IW'(k);
      end
    end
  end

  always_comb begin
    idx_sum = {1'b0, rr_ptr} + {1'b0, off};
    if (idx_sum >= (IW+1)'(N_REQ)) begin
      idx_sum = idx_sum - (IW+1)'(N_REQ);
    end
  end

  assign win_idx = idx_sum[IW-1:0];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_oh
      assign win_oh[gi] = win_vld && (win_idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Round-robin scheduler sharing one SPI shift engine between N_REQ requesters;
// grants, latches the winner's mode/data, launches the engine and reports done.
module spi_xfer_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DFLT,
  parameter int DW      = 8,
  parameter int GAP_CYC = 4,
  parameter int TO_CYC  = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_cpol,
  input  logic [N_REQ-1:0]         req_cpha,
  input  logic [N_REQ*DW-1:0]      req_dat,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic                     err,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] active_id,
  output logic                     eng_start,
  output logic                     eng_cpol,
  output logic                     eng_cpha,
  output logic [DW-1:0]            eng_dat,
  input  logic                     eng_cs
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TO_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  state_t             state_reg;
  logic [IW-1:0]      rr_ptr_reg;
  logic [TW-1:0]      timer_reg;
  logic [GW-1:0]      gap_cnt_reg;
  logic [N_REQ-1:0]   gnt_reg;
  logic [N_REQ-1:0]   done_reg;
  logic               err_reg;
  logic               busy_reg;
  logic [IW-1:0]      active_id_reg;
  logic               eng_start_reg;
  logic               eng_cpol_reg;
  logic               eng_cpha_reg;
  logic [DW-1:0]      eng_dat_reg;

  logic [N_REQ-1:0]   win_oh;
  logic [IW-1:0]      win_idx;
  logic               win_vld;
  logic               wait_expired;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req     (req),
    .rr_ptr  (rr_ptr_reg),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  // Leaving on TO_CYC-1 puts done/err TO_CYC+1 cycles after LAUNCH.
  assign wait_expired = (timer_reg == TW'(TO_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      timer_reg     <= '0;
      gap_cnt_reg   <= '0;
      gnt_reg       <= '0;
      done_reg      <= '0;
      err_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      active_id_reg <= '0;
      eng_start_reg <= 1'b0;
      {eng_cpol_reg, eng_cpha_reg} <= MODE0;
      eng_dat_reg   <= '0;
    end else begin
      eng_start_reg <= 1'b0;
      done_reg      <= '0;
      err_reg       <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|req) begin
            state_reg <= ARB;
            busy_reg  <= 1'b1;
          end
        end
        ARB: begin
          if (win_vld) begin
            gnt_reg       <= win_oh;
            active_id_reg <= win_idx;
            {eng_cpol_reg, eng_cpha_reg} <= mode_of(req_cpol[win_idx], req_cpha[win_idx]);
            eng_dat_reg   <= req_dat[int'(win_idx)*DW +: DW];
            state_reg     <= LAUNCH;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        LAUNCH: begin
          eng_start_reg <= 1'b1;
          timer_reg     <= '0;
          state_reg     <= WAIT_LO;
        end
        WAIT_LO: begin
          // A cs already low from a stale engine counts as the transfer start.
          if (!eng_cs) begin
            timer_reg <= '0;
            state_reg <= WAIT_HI;
          end else if (wait_expired) begin
            timer_reg <= TW'(TO_CYC);
            done_reg  <= gnt_reg;
            err_reg   <= 1'b1;
            state_reg <= FIN;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        WAIT_HI: begin
          if (eng_cs) begin
            done_reg  <= gnt_reg;
            state_reg <= FIN;
          end else if (wait_expired) begin
            timer_reg <= TW'(TO_CYC);
            done_reg  <= gnt_reg;
            err_reg   <= 1'b1;
            state_reg <= FIN;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        FIN: begin
          gnt_reg     <= '0;
          gap_cnt_reg <= '0;
          rr_ptr_reg  <= (active_id_reg == IW'(N_REQ - 1)) ? '0 : active_id_reg + IW'(1);
          state_reg   <= GAP;
        end
        GAP: begin
          if (gap_cnt_reg == GW'(GAP_CYC - 1)) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign busy      = busy_reg;
  assign active_id = active_id_reg;
  assign eng_start = eng_start_reg;
  assign eng_cpol  = eng_cpol_reg;
  assign eng_cpha  = eng_cpha_reg;
  assign eng_dat   = eng_dat_reg;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Scoreboard bench for spi_xfer_arbiter with a simple SPI engine model.
module tb_spi_xfer_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int GAP = 4;
  localparam int TO  = 255;
  localparam int IW  = 2;

  typedef struct {
    int         id;
    logic [7:0] dat;
    logic       cpol;
    logic       cpha;
    logic       err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_cpol = '0;
  logic [N-1:0]    req_cpha = '0;
  logic [N*DW-1:0] req_dat = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic            err;
  logic            busy;
  logic [IW-1:0]   active_id;
  logic            eng_start;
  logic            eng_cpol;
  logic            eng_cpha;
  logic [DW-1:0]   eng_dat;
  logic            eng_cs = 1'b1;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   cs_rise_cyc = 0;
  int   lo_dly = 3;
  int   hi_dly = 34;
  bit   eng_hang = 1'b0;
  exp_t sb[$];

  spi_xfer_arbiter #(
    .N_REQ   (N),
    .DW      (DW),
    .GAP_CYC (GAP),
    .TO_CYC  (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_cpol  (req_cpol),
    .req_cpha  (req_cpha),
    .req_dat   (req_dat),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .active_id (active_id),
    .eng_start (eng_start),
    .eng_cpol  (eng_cpol),
    .eng_cpha  (eng_cpha),
    .eng_dat   (eng_dat),
    .eng_cs    (eng_cs)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Engine model: cs low lo_dly cycles after start, high hi_dly cycles later.
  initial forever begin
    @(negedge clk);
    if (eng_start && !eng_hang) begin
      repeat (lo_dly) @(negedge clk);
      eng_cs = 1'b0;
      repeat (hi_dly) @(negedge clk);
      eng_cs = 1'b1;
      cs_rise_cyc = cyc;
    end
  end

  // Scoreboard monitor: capture launched config, compare on each done.
  initial begin : mon
    exp_t       e;
    logic [7:0] cap_dat;
    logic       cap_cpol;
    logic       cap_cpha;
    logic [N-1:0] exp_oh;
    cap_dat = '0; cap_cpol = 1'b0; cap_cpha = 1'b0;
    forever begin
      @(negedge clk);
      if (eng_start) begin
        cap_dat  = eng_dat;
        cap_cpol = eng_cpol;
        cap_cpha = eng_cpha;
      end
      if (done != '0) begin
        done_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_done: done=%b, no transfer expected", done);
        end else begin
          e = sb.pop_front();
          exp_oh = '0;
          exp_oh[e.id] = 1'b1;
          $display("TXN id=%0d dat=%h cpol=%b cpha=%b err=%b", active_id, cap_dat, cap_cpol, cap_cpha, err);
          if (done !== exp_oh || gnt !== exp_oh || active_id !== IW'(e.id) || err !== e.err ||
              cap_dat !== e.dat || cap_cpol !== e.cpol || cap_cpha !== e.cpha) begin
            errors++;
            $display("FAIL sb_txn: got done=%b gnt=%b id=%0d err=%b dat=%h mode=%b%b, want done=%b id=%0d err=%b dat=%h mode=%b%b",
                     done, gnt, active_id, err, cap_dat, cap_cpol, cap_cpha,
                     exp_oh, e.id, e.err, e.dat, e.cpol, e.cpha);
          end
        end
      end
    end
  end

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b, want 0 within 50 cycles", busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, done, err, busy, active_id, eng_start, eng_cpol, eng_cpha, eng_dat} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b done=%b err=%b busy=%b id=%0d start=%b mode=%b%b dat=%h, want all 0",
               gnt, done, err, busy, active_id, eng_start, eng_cpol, eng_cpha, eng_dat);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b gnt=%b, want 0/0000", busy, gnt);
    end
  endtask

  task automatic test_fairness();
    int order[5] = '{0, 1, 2, 3, 0};
    bit ok;
    bit bad;
    bit got;
    int d_cyc;
    lo_dly = 2;
    hi_dly = 6;
    for (int i = 0; i < N; i++) req_dat[i*DW +: DW] = 8'(17 * (i + 1));
    req_cpol = '0;
    req_cpha = '0;
    for (int t = 0; t < 5; t++) sb.push_back('{order[t], 8'(17 * (order[t] + 1)), 1'b0, 1'b0, 1'b0});
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_done(200, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL fair_done_timeout: transfer %0d got no done, want done", t);
        break;
      end
      if (t == 4) begin
        req = '0;
      end else begin
        d_cyc = cyc;
        bad = 1'b0;
        for (int k = 0; k < GAP; k++) begin
          @(negedge clk);
          if (!busy || gnt != '0) bad = 1'b1;
        end
        @(negedge clk);
        if (busy) bad = 1'b1;
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL fair_gap_busy: busy=%b gnt=%b, want %0d busy cycles then idle", busy, gnt, GAP);
        end
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
          if (gnt != '0) got = 1'b1;
          else @(negedge clk);
        end
        checks++;
        if (!got || (cyc - d_cyc) != GAP + 3) begin
          errors++;
          $display("FAIL fair_regrant: gnt %0d cycles after done, want %0d", cyc - d_cyc, GAP + 3);
        end
      end
    end
    wait_idle();
  endtask

  task automatic test_single();
    bit ok;
    lo_dly = 3;
    hi_dly = 34;
    req_dat[0 +: DW] = 8'hA5;
    req_cpol[0] = 1'b0;
    req_cpha[0] = 1'b0;
    sb.push_back('{0, 8'hA5, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_arb: gnt=%b busy=%b, want 0000/1", gnt, busy);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || eng_start !== 1'b0 || active_id !== 2'd0) begin
      errors++;
      $display("FAIL single_gnt: gnt=%b start=%b id=%0d, want 0001/0/0", gnt, eng_start, active_id);
    end
    @(negedge clk);
    checks++;
    if (eng_start !== 1'b1 || eng_dat !== 8'hA5) begin
      errors++;
      $display("FAIL single_start: start=%b dat=%h, want 1/a5", eng_start, eng_dat);
    end
    wait_done(100, ok);
    checks++;
    if (!ok || cyc != cs_rise_cyc + 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL single_done: ok=%b done_cyc=%0d err=%b, want done at %0d err 0", ok, cyc, err, cs_rise_cyc + 1);
    end
    req = '0;
    wait_idle();
  endtask

  task automatic test_config_latch();
    bit ok;
    bit bad;
    lo_dly = 3;
    hi_dly = 12;
    req_dat[2*DW +: DW] = 8'h3C;
    req_cpol[2] = 1'b1;
    req_cpha[2] = 1'b1;
    sb.push_back('{2, 8'h3C, 1'b1, 1'b1, 1'b0});
    req = 4'b0100;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (gnt != '0) ok = 1'b1;
    end
    checks++;
    if (!ok || gnt !== 4'b0100) begin
      errors++;
      $display("FAIL cfg_gnt: gnt=%b, want 0100", gnt);
    end
    req_dat[2*DW +: DW] = 8'hFF;
    req_cpol[2] = 1'b0;
    req_cpha[2] = 1'b0;
    bad = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (eng_dat !== 8'h3C || eng_cpol !== 1'b1 || eng_cpha !== 1'b1) bad = 1'b1;
      if (done != '0) ok = 1'b1;
    end
    checks++;
    if (bad || !ok) begin
      errors++;
      $display("FAIL cfg_hold: dat=%h mode=%b%b done_seen=%b, want 3c/11 until done", eng_dat, eng_cpol, eng_cpha, ok);
    end
    req = '0;
    wait_idle();
  endtask

  task automatic test_timeout();
    bit ok;
    int s_cyc;
    eng_hang = 1'b1;
    req_dat[3*DW +: DW] = 8'h5A;
    req_cpol[3] = 1'b1;
    req_cpha[3] = 1'b0;
    sb.push_back('{3, 8'h5A, 1'b1, 1'b0, 1'b1});
    req = 4'b1000;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (eng_start) ok = 1'b1;
    end
    s_cyc = cyc;
    wait_done(TO + 50, ok);
    checks++;
    if (!ok || err !== 1'b1 || (cyc - s_cyc) != TO) begin
      errors++;
      $display("FAIL timeout_done: ok=%b err=%b delay=%0d, want err 1 after %0d cycles from start", ok, err, cyc - s_cyc, TO);
    end
    req = '0;
    eng_hang = 1'b0;
    wait_idle();
    lo_dly = 2;
    hi_dly = 5;
    req_dat[1*DW +: DW] = 8'hC3;
    req_cpol[1] = 1'b0;
    req_cpha[1] = 1'b1;
    sb.push_back('{1, 8'hC3, 1'b0, 1'b1, 1'b0});
    req = 4'b0010;
    wait_done(100, ok);
    checks++;
    if (!ok || err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover: ok=%b err=%b, want done with err 0", ok, err);
    end
    req = '0;
    wait_idle();
  endtask

  task automatic test_reset_midxfer();
    bit ok;
    int dc;
    lo_dly = 2;
    hi_dly = 30;
    req_dat[0 +: DW] = 8'h77;
    sb.push_back('{0, 8'h77, 1'b0, 0, 1'b0});
    req = 4'b0001;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (!eng_cs) ok = 1'b1;
    end
    repeat (3) @(negedge clk);
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, done, err, busy, active_id, eng_start, eng_cpol, eng_cpha, eng_dat} !== '0) begin
      errors++;
      $display("FAIL rst_async: gnt=%b done=%b err=%b busy=%b id=%0d start=%b dat=%h, want all 0",
               gnt, done, err, busy, active_id, eng_start, eng_dat);
    end
    sb.delete();
    req = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (eng_cs) ok = 1'b1;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || done_cnt != dc) begin
      errors++;
      $display("FAIL rst_no_done: dones=%0d cs_high=%b, want %0d dones and cs high", done_cnt, ok, dc);
    end
    lo_dly = 2;
    hi_dly = 5;
    req_dat[2*DW +: DW] = 8'h96;
    req_cpol[2] = 1'b0;
    req_cpha[2] = 1'b0;
    sb.push_back('{2, 8'h96, 1'b0, 1'b0, 1'b0});
    req = 4'b0100;
    wait_done(100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_regrant: no done, want done[2]");
    end
    req = '0;
    wait_idle();
  endtask

  task automatic test_withdraw();
    bit ok;
    lo_dly = 5;
    hi_dly = 10;
    req_dat[1*DW +: DW] = 8'h5E;
    req_cpol[1] = 1'b1;
    req_cpha[1] = 1'b0;
    sb.push_back('{1, 8'h5E, 1'b1, 1'b0, 1'b0});
    req = 4'b0010;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (eng_start) ok = 1'b1;
    end
    req = '0;
    wait_done(100, ok);
    checks++;
    if (!ok || done !== 4'b0010) begin
      errors++;
      $display("FAIL withdraw_done: done=%b, want 0010", done);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_config_latch();
    test_timeout();
    test_reset_midxfer();
    test_withdraw();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d pending, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
